// File: rtl/eq_pkg.sv
// Shared equaliser definitions: band count, gain field format and gain controller states.
package eq_pkg;

    localparam int NUMBER_OF_FILTERS = 10;
    localparam int GAIN_BITS         = 4;
    localparam int BAND_BITS         = 4;
    localparam int DEFAULT_GAIN      = 1;
    localparam int RAMP_SAMPLES      = 8;

    typedef logic [GAIN_BITS-1:0] gain_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/gain_stepper.sv
// One band of the ramp: moves live one LSB toward target when step is high.
module gain_stepper #(
    parameter int GAIN_BITS = 4
) (
    input  logic [GAIN_BITS-1:0] live,
    input  logic [GAIN_BITS-1:0] target,
    input  logic                 step,
    output logic [GAIN_BITS-1:0] next_live,
    output logic                 eq
);

    always_comb begin
        eq        = (live == target);
        next_live = live;
        if (step && (live < target))
            next_live = live + 1'b1;
        else if (step && (live > target))
            next_live = live - 1'b1;
    end

endmodule

// File: rtl/eq_gain_ctrl.sv
// Per-band gain producer for the equaliser: shadow writes, commit to target,
// then click-free ramp of the live gains paced by the sample strobe.
module eq_gain_ctrl
    import eq_pkg::*;
#(
    parameter int NUMBER_OF_FILTERS = eq_pkg::NUMBER_OF_FILTERS,
    parameter int GAIN_BITS         = eq_pkg::GAIN_BITS,
    parameter int DEFAULT_GAIN      = eq_pkg::DEFAULT_GAIN,
    parameter int RAMP_SAMPLES      = eq_pkg::RAMP_SAMPLES,
    parameter int BAND_BITS         = eq_pkg::BAND_BITS
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   sample_en,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [BAND_BITS-1:0]                   wr_band,
    input  logic [GAIN_BITS-1:0]                   wr_gain,
    input  logic                                   commit_valid,
    output logic                                   commit_ready,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] gain_out,
    output logic                                   ramp_busy,
    output logic                                   ramp_done,
    output logic                                   err_band
);

    localparam int CNT_W = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_SAMPLES - 1);

    typedef logic [NUMBER_OF_FILTERS-1:0][GAIN_BITS-1:0] bank_t;
    localparam bank_t DEF_BANK = {NUMBER_OF_FILTERS{GAIN_BITS'(DEFAULT_GAIN)}};

    state_t                         state, state_nxt;
    logic [CNT_W-1:0]               cnt, cnt_nxt;
    bank_t                          live, target, shadow, shadow_nxt, live_nxt;
    logic [NUMBER_OF_FILTERS-1:0]   eq_vec;
    logic                           all_eq, step, commit_acc, ramp_end, done_q;

    assign wr_ready   = 1'b1;
    assign gain_out   = live;
    assign all_eq     = &eq_vec;
    assign commit_acc = commit_valid & commit_ready;
    assign ramp_done  = done_q | ramp_end;

    // Same-cycle write is folded in here so a commit copies it too.
    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < NUMBER_OF_FILTERS; i++)
            if (wr_valid && (int'(wr_band) == i))
                shadow_nxt[i] = wr_gain;
    end

    for (genvar b = 0; b < NUMBER_OF_FILTERS; b++) begin : g_band
        gain_stepper #(.GAIN_BITS(GAIN_BITS)) u_step (
            .live      (live[b]),
            .target    (target[b]),
            .step      (step),
            .next_live (live_nxt[b]),
            .eq        (eq_vec[b])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        step         = 1'b0;
        commit_ready = 1'b0;
        ramp_busy    = 1'b0;
        ramp_end     = 1'b0;
        case (state)
            IDLE: begin
                commit_ready = 1'b1;
                if (commit_valid) begin
                    cnt_nxt = '0;
                    if (shadow_nxt != live)
                        state_nxt = RAMP;
                end
            end
            RAMP: begin
                ramp_busy = 1'b1;
                if (all_eq) begin
                    state_nxt = IDLE;
                    ramp_end  = 1'b1;
                end else if (sample_en) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        step    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live     <= DEF_BANK;
            target   <= DEF_BANK;
            shadow   <= DEF_BANK;
            done_q   <= 1'b0;
            err_band <= 1'b0;
        end else begin
            live     <= live_nxt;
            shadow   <= shadow_nxt;
            err_band <= wr_valid && (int'(wr_band) >= NUMBER_OF_FILTERS);
            done_q   <= commit_acc && (shadow_nxt == live);
            if (commit_acc)
                target <= shadow_nxt;
        end
    end

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Scoreboard bench for eq_gain_ctrl: stimulus queues expected gain/done/err events,
// a negedge monitor pops and compares them, including the strobe count at each step.
module tb_eq_gain_ctrl;
    import eq_pkg::*;

    localparam int NF = 10;
    localparam int GB = 4;
    localparam int K_GAIN = 0, K_DONE = 1, K_ERR = 2;

    typedef logic [NF-1:0][GB-1:0] bank_t;
    typedef struct {
        int    kind;
        bank_t val;
        int    strobe;
    } exp_t;

    logic           clk = 1'b0, reset_n = 1'b0, sample_en = 1'b0;
    logic           wr_valid = 1'b0, commit_valid = 1'b0;
    logic [3:0]     wr_band = '0;
    logic [GB-1:0]  wr_gain = '0;
    logic           wr_ready, commit_ready, ramp_busy, ramp_done, err_band;
    logic [NF*GB-1:0] gain_out;

    exp_t  sbq[$];
    int    nvec = 0, nerr = 0, strobes = 0, base = 0;
    logic  en_enable = 1'b1, phase = 1'b0;
    bank_t def_bank, exp_bank, snap;

    eq_gain_ctrl dut (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_band(wr_band), .wr_gain(wr_gain),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .gain_out(gain_out),
        .ramp_busy(ramp_busy), .ramp_done(ramp_done), .err_band(err_band)
    );

    always #5 clk = ~clk;

    // Strobe every other cycle while enabled.
    always @(posedge clk) begin
        #1;
        sample_en = en_enable && phase;
        phase     = !phase;
    end

    always @(posedge clk) if (sample_en) strobes <= strobes + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction

    function automatic void push(int kind, bank_t val, int strobe);
        exp_t e;
        e.kind = kind; e.val = val; e.strobe = strobe;
        sbq.push_back(e);
    endfunction

    function automatic void pop_cmp(int kind, bank_t val);
        exp_t e;
        if (sbq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_event: got kind %0d val %0h expected none", kind, val);
            return;
        end
        e = sbq.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        if (kind == K_GAIN && e.kind == K_GAIN) chk("gain_out", 64'(val), 64'(e.val));
        if (e.strobe >= 0) chk("step_strobe", 64'(strobes), 64'(e.strobe));
    endfunction

    initial begin : monitor
        bank_t prev;
        prev = {NF{4'd1}};
        forever begin
            @(negedge clk);
            if (gain_out !== prev) begin
                pop_cmp(K_GAIN, gain_out);
                prev = gain_out;
            end
            if (ramp_done === 1'b1) pop_cmp(K_DONE, '0);
            if (err_band === 1'b1) pop_cmp(K_ERR, '0);
        end
    end

    task automatic wr(input int band, input int gain);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_band = 4'(band); wr_gain = GB'(gain);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic commit();
        @(posedge clk); #1;
        commit_valid = 1'b1;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        base = strobes;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok;
        ok = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (!ramp_busy) ok = 1;
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL ramp_timeout: ramp_busy still 1 after %0d cycles, expected 0", max_cyc);
        end
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_gain_out"}, 64'(gain_out), 64'(def_bank));
        chk({tag, "_commit_ready"}, 64'(commit_ready), 64'd1);
        chk({tag, "_ramp_busy"}, 64'(ramp_busy), 64'd0);
        chk({tag, "_ramp_done"}, 64'(ramp_done), 64'd0);
        chk({tag, "_err_band"}, 64'(err_band), 64'd0);
    endtask

    initial begin
        def_bank = {NF{4'd1}};
        repeat (3) @(posedge clk);
        #1 check_reset_state("rst");
        reset_n = 1'b1;
        @(posedge clk); #1 check_reset_state("post_rst");
        chk("wr_ready", 64'(wr_ready), 64'd1);

        // Reset mid-ramp: band5 -> 10, abort after first step.
        wr(5, 10);
        commit();
        exp_bank = def_bank; exp_bank[5] = 4'd2;
        push(K_GAIN, exp_bank, base + 8);
        repeat (30) @(posedge clk);
        push(K_GAIN, def_bank, -1);
        #3 reset_n = 1'b0;
        #1 check_reset_state("midramp_rst");
        @(posedge clk); #1 reset_n = 1'b1;

        // band3: 1 -> 5, one step per 8 strobes.
        wr(3, 5);
        commit();
        chk("busy_after_commit", 64'(ramp_busy), 64'd1);
        chk("ready_in_ramp", 64'(commit_ready), 64'd0);
        exp_bank = def_bank;
        for (int k = 1; k <= 4; k++) begin
            exp_bank[3] = GB'(1 + k);
            push(K_GAIN, exp_bank, base + 8 * k);
        end
        push(K_DONE, '0, -1);
        wait_idle(1000);

        // band0 -> 0 (one step), band9 -> 15 (14 steps).
        wr(0, 0);
        wr(9, 15);
        commit();
        for (int k = 1; k <= 14; k++) begin
            exp_bank[0] = 4'd0;
            exp_bank[9] = GB'(1 + k);
            push(K_GAIN, exp_bank, base + 8 * k);
        end
        push(K_DONE, '0, -1);
        repeat (40) @(posedge clk);
        #1 en_enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        snap = gain_out;
        begin
            int s0;
            s0 = strobes;
            repeat (50) @(negedge clk);
            chk("freeze_gain", 64'(gain_out), 64'(snap));
            chk("freeze_busy", 64'(ramp_busy), 64'd1);
            chk("freeze_strobes", 64'(strobes), 64'(s0));
        end
        en_enable = 1'b1;

        // Commit refused mid-ramp; shadow band2=9 written alongside.
        @(posedge clk); #1;
        commit_valid = 1'b1; wr_valid = 1'b1; wr_band = 4'd2; wr_gain = 4'd9;
        @(negedge clk);
        chk("ready_refused", 64'(commit_ready), 64'd0);
        @(posedge clk); #1 wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 commit_valid = 1'b0;
        wait_idle(1000);

        // Same-cycle write band2=7 + commit: target takes 7, not 9.
        @(posedge clk); #1;
        commit_valid = 1'b1; wr_valid = 1'b1; wr_band = 4'd2; wr_gain = 4'd7;
        @(posedge clk); #1;
        commit_valid = 1'b0; wr_valid = 1'b0;
        base = strobes;
        for (int k = 1; k <= 6; k++) begin
            exp_bank[2] = GB'(1 + k);
            push(K_GAIN, exp_bank, base + 8 * k);
        end
        push(K_DONE, '0, -1);
        wait_idle(1000);

        // Out-of-range band, then a no-op commit.
        push(K_ERR, '0, -1);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_band = 4'd12; wr_gain = 4'd3;
        @(posedge clk); #1 wr_valid = 1'b0;
        @(negedge clk);
        chk("err_band_pulse", 64'(err_band), 64'd1);
        @(negedge clk);
        chk("err_band_clear", 64'(err_band), 64'd0);
        push(K_DONE, '0, -1);
        commit();
        chk("noop_busy", 64'(ramp_busy), 64'd0);
        chk("noop_ready", 64'(commit_ready), 64'd1);
        chk("noop_done", 64'(ramp_done), 64'd1);
        @(posedge clk); #1;
        chk("noop_done_clear", 64'(ramp_done), 64'd0);
        chk("final_gain", 64'(gain_out), 64'(exp_bank));

        repeat (10) @(posedge clk);
        while (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            nvec++; nerr++;
            $display("FAIL missing_event: got nothing expected kind %0d val %0h", e.kind, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
